// File: rtl/gtfmac_pmtick_statsbank.sv
// Multi-channel pm_tick statistics bank: split LSB/MSB interval counters per channel,
// coherent snapshot on pm_tick, held outputs and a registered channel read port.
module gtfmac_pmtick_statsbank #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned INWIDTH  = 4,
  parameter int unsigned OUTWIDTH = 48,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned SELW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pm_tick,
  input  logic [NUM_CH*INWIDTH-1:0]    pulsein,
  input  logic                         hold_output,
  input  logic                         rd_en,
  input  logic [SELW-1:0]              rd_sel,
  output logic [NUM_CH*OUTWIDTH-1:0]   statsout,
  output logic [NUM_CH-1:0]            ovf_out,
  output logic                         snapshot_valid,
  output logic [OUTWIDTH-1:0]          rd_data,
  output logic                         rd_ovf,
  output logic                         rd_valid
);

  localparam int unsigned HW = OUTWIDTH / 2;

  logic                pm_tick_r_q, pm_tick_r_d;
  logic                pm_tick_d1_q, pm_tick_d1_d;
  logic [HW-1:0]       lsb_q [NUM_CH];
  logic [HW-1:0]       lsb_d [NUM_CH];
  logic [NUM_CH-1:0]   lsb_ovf_q, lsb_ovf_d;
  logic [HW-1:0]       lsb_d1_q [NUM_CH];
  logic [HW-1:0]       lsb_d1_d [NUM_CH];
  logic [HW-1:0]       msb_q [NUM_CH];
  logic [HW-1:0]       msb_d [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [OUTWIDTH-1:0] statshold_q [NUM_CH];
  logic [OUTWIDTH-1:0] statshold_d [NUM_CH];
  logic [NUM_CH-1:0]   ovf_hold_q, ovf_hold_d;
  logic [OUTWIDTH-1:0] statsout_q [NUM_CH];
  logic [OUTWIDTH-1:0] statsout_d [NUM_CH];
  logic [NUM_CH-1:0]   ovf_out_q, ovf_out_d;
  logic                snapshot_valid_q, snapshot_valid_d;
  logic                rd_req_q, rd_req_d;
  logic [SELW-1:0]     rd_sel_q, rd_sel_d;
  logic [OUTWIDTH-1:0] rd_data_q, rd_data_d;
  logic                rd_ovf_q, rd_ovf_d;
  logic                rd_valid_q, rd_valid_d;
  logic [HW:0]         lsb_sum [NUM_CH];
  logic [HW:0]         msb_sum [NUM_CH];

  always_comb begin
    pm_tick_r_d      = pm_tick;
    pm_tick_d1_d     = pm_tick_r_q;
    snapshot_valid_d = pm_tick_d1_q;
    lsb_ovf_d        = '0;
    ovf_d            = '0;
    ovf_hold_d       = ovf_hold_q;
    ovf_out_d        = hold_output ? ovf_out_q : ovf_hold_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      lsb_sum[c]     = {1'b0, lsb_q[c]} + (HW+1)'(pulsein[c*INWIDTH +: INWIDTH]);
      msb_sum[c]     = {1'b0, msb_q[c]} + {{HW{1'b0}}, lsb_ovf_q[c]};
      lsb_d[c]       = lsb_sum[c][HW-1:0];
      msb_d[c]       = msb_sum[c][HW-1:0];
      statshold_d[c] = statshold_q[c];
      statsout_d[c]  = hold_output ? statsout_q[c] : statshold_q[c];

      if (pm_tick_r_q) begin
        lsb_d[c]     = HW'(pulsein[c*INWIDTH +: INWIDTH]);
        lsb_ovf_d[c] = 1'b0;
      end else begin
        lsb_ovf_d[c] = lsb_sum[c][HW];
      end

      // lsb_ovf is always cleared the edge before pm_tick_d1, so no carry is dropped here
      if (pm_tick_d1_q) begin
        msb_d[c]       = '0;
        ovf_d[c]       = 1'b0;
        statshold_d[c] = {msb_q[c], lsb_d1_q[c]};
        ovf_hold_d[c]  = ovf_q[c];
      end else if (SATURATE && (ovf_q[c] || msb_sum[c][HW])) begin
        msb_d[c] = '1;
        ovf_d[c] = 1'b1;
      end else begin
        ovf_d[c] = ovf_q[c] | msb_sum[c][HW];
      end

      // Saturate on the flag's next value so a carry landing on the final edge still clamps
      lsb_d1_d[c] = (SATURATE && ovf_d[c]) ? '1 : lsb_q[c];
    end

    rd_req_d   = rd_en;
    rd_sel_d   = rd_sel;
    rd_valid_d = rd_req_q;
    rd_data_d  = rd_data_q;
    rd_ovf_d   = rd_ovf_q;
    if (rd_req_q) begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rd_sel_q == SELW'(c)) begin
          rd_data_d = statsout_q[c];
          rd_ovf_d  = ovf_out_q[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_tick_r_q      <= 1'b0;
      pm_tick_d1_q     <= 1'b0;
      lsb_q            <= '{default: '0};
      lsb_ovf_q        <= '0;
      lsb_d1_q         <= '{default: '0};
      msb_q            <= '{default: '0};
      ovf_q            <= '0;
      statshold_q      <= '{default: '0};
      ovf_hold_q       <= '0;
      statsout_q       <= '{default: '0};
      ovf_out_q        <= '0;
      snapshot_valid_q <= 1'b0;
      rd_req_q         <= 1'b0;
      rd_sel_q         <= '0;
      rd_data_q        <= '0;
      rd_ovf_q         <= 1'b0;
      rd_valid_q       <= 1'b0;
    end else begin
      pm_tick_r_q      <= pm_tick_r_d;
      pm_tick_d1_q     <= pm_tick_d1_d;
      lsb_q            <= lsb_d;
      lsb_ovf_q        <= lsb_ovf_d;
      lsb_d1_q         <= lsb_d1_d;
      msb_q            <= msb_d;
      ovf_q            <= ovf_d;
      statshold_q      <= statshold_d;
      ovf_hold_q       <= ovf_hold_d;
      statsout_q       <= statsout_d;
      ovf_out_q        <= ovf_out_d;
      snapshot_valid_q <= snapshot_valid_d;
      rd_req_q         <= rd_req_d;
      rd_sel_q         <= rd_sel_d;
      rd_data_q        <= rd_data_d;
      rd_ovf_q         <= rd_ovf_d;
      rd_valid_q       <= rd_valid_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign statsout[g*OUTWIDTH +: OUTWIDTH] = statsout_q[g];
  end

  assign ovf_out        = ovf_out_q;
  assign snapshot_valid = snapshot_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_ovf         = rd_ovf_q;
  assign rd_valid       = rd_valid_q;

endmodule

// File: tb/tb_gtfmac_pmtick_statsbank.sv
// Directed bench for gtfmac_pmtick_statsbank: a 4x48 saturating bank plus 3x8 saturating
// and wrapping banks sharing the same stimulus.
module tb_gtfmac_pmtick_statsbank;

  logic        clk = 1'b0;
  logic        reset;
  logic        pm_tick;
  logic [15:0] pulsein;
  logic        hold_output;
  logic        rd_en;
  logic [1:0]  rd_sel;

  logic [191:0] so_m;
  logic [3:0]   ovf_m;
  logic         sv_m, rov_m, rv_m;
  logic [47:0]  rd_m;

  logic [23:0]  so_s, so_w;
  logic [2:0]   ovf_s, ovf_w;
  logic         sv_s, rov_s, rv_s, sv_w, rov_w, rv_w;
  logic [7:0]   rd_s, rd_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gtfmac_pmtick_statsbank #(.NUM_CH(4), .INWIDTH(4), .OUTWIDTH(48), .SATURATE(1'b1)) dut_main (
    .clk(clk), .reset(reset), .pm_tick(pm_tick), .pulsein(pulsein),
    .hold_output(hold_output), .rd_en(rd_en), .rd_sel(rd_sel),
    .statsout(so_m), .ovf_out(ovf_m), .snapshot_valid(sv_m),
    .rd_data(rd_m), .rd_ovf(rov_m), .rd_valid(rv_m)
  );

  gtfmac_pmtick_statsbank #(.NUM_CH(3), .INWIDTH(4), .OUTWIDTH(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .pm_tick(pm_tick), .pulsein(pulsein[11:0]),
    .hold_output(hold_output), .rd_en(rd_en), .rd_sel(rd_sel),
    .statsout(so_s), .ovf_out(ovf_s), .snapshot_valid(sv_s),
    .rd_data(rd_s), .rd_ovf(rov_s), .rd_valid(rv_s)
  );

  gtfmac_pmtick_statsbank #(.NUM_CH(3), .INWIDTH(4), .OUTWIDTH(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .pm_tick(pm_tick), .pulsein(pulsein[11:0]),
    .hold_output(hold_output), .rd_en(rd_en), .rd_sel(rd_sel),
    .statsout(so_w), .ovf_out(ovf_w), .snapshot_valid(sv_w),
    .rd_data(rd_w), .rd_ovf(rov_w), .rd_valid(rv_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; pm_tick = 1'b0; pulsein = '0; hold_output = 1'b0;
    rd_en = 1'b0; rd_sel = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (so_m !== '0) begin errors++; $display("FAIL reset_statsout got %0h exp 0", so_m); end
    checks++; if (ovf_m !== '0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", ovf_m); end
    checks++; if ({sv_m, rv_m, rov_m} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {sv_m, rv_m, rov_m}); end
    checks++; if (rd_m !== '0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_m); end
    checks++; if ({so_s, so_w} !== '0) begin errors++; $display("FAIL reset_small_statsout got %0h exp 0", {so_s, so_w}); end
  endtask

  task automatic test_counts();
    logic [47:0] exp_ch [4];
    exp_ch[0] = 48'd100; exp_ch[1] = 48'd200; exp_ch[2] = 48'd300; exp_ch[3] = 48'd1500;
    apply_reset();
    pulsein = 16'hF321;
    repeat (100) tick();
    pulsein = '0; pm_tick = 1'b1;
    tick();                       // edge 0
    pm_tick = 1'b0;
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL counts_sv_e0 got %b exp 0", sv_m); end
    tick();                       // edge 1
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL counts_sv_e1 got %b exp 0", sv_m); end
    tick();                       // edge 2
    checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL counts_sv_e2 got %b exp 1", sv_m); end
    checks++; if (so_m !== '0) begin errors++; $display("FAIL counts_statsout_e2 got %0h exp 0", so_m); end
    tick();                       // edge 3
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL counts_sv_e3 got %b exp 0", sv_m); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (so_m[c*48 +: 48] !== exp_ch[c]) begin
        errors++; $display("FAIL counts_ch%0d got %0d exp %0d", c, so_m[c*48 +: 48], exp_ch[c]);
      end
    end
    checks++; if (ovf_m !== 4'b0000) begin errors++; $display("FAIL counts_ovf got %b exp 0000", ovf_m); end
  endtask

  task automatic test_read();
    rd_en = 1'b1; rd_sel = 2'd1;
    tick();                       // edge k
    rd_sel = 2'd3;
    checks++; if (rv_m !== 1'b0) begin errors++; $display("FAIL read_valid_early got %b exp 0", rv_m); end
    tick();                       // edge k+1
    rd_en = 1'b0;
    checks++; if (rv_m !== 1'b1) begin errors++; $display("FAIL read_valid_1 got %b exp 1", rv_m); end
    checks++; if (rd_m !== 48'd200) begin errors++; $display("FAIL read_data_ch1 got %0d exp 200", rd_m); end
    tick();
    checks++; if (rv_m !== 1'b1) begin errors++; $display("FAIL read_valid_2 got %b exp 1", rv_m); end
    checks++; if (rd_m !== 48'd1500) begin errors++; $display("FAIL read_data_ch3 got %0d exp 1500", rd_m); end
    tick();
    checks++; if (rv_m !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %b exp 0", rv_m); end
    checks++; if (rd_m !== 48'd1500) begin errors++; $display("FAIL read_data_hold got %0d exp 1500", rd_m); end
  endtask

  task automatic snapshot_seq();
    pulsein = '0; pm_tick = 1'b1;
    tick();
    pm_tick = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_sat_wrap();
    apply_reset();
    pulsein = 16'h000F;
    repeat (20) tick();
    snapshot_seq();
    checks++; if (so_s[7:0] !== 8'd255) begin errors++; $display("FAIL sat_value got %0d exp 255", so_s[7:0]); end
    checks++; if (ovf_s !== 3'b001) begin errors++; $display("FAIL sat_ovf got %b exp 001", ovf_s); end
    checks++; if (so_w[7:0] !== 8'd44) begin errors++; $display("FAIL wrap_value got %0d exp 44", so_w[7:0]); end
    checks++; if (ovf_w !== 3'b001) begin errors++; $display("FAIL wrap_ovf got %b exp 001", ovf_w); end
    checks++; if (so_s[15:8] !== 8'd0) begin errors++; $display("FAIL sat_ch1 got %0d exp 0", so_s[15:8]); end
    rd_en = 1'b1; rd_sel = 2'd0;
    tick();
    rd_sel = 2'd3;
    tick();
    rd_en = 1'b0;
    checks++; if ({rv_s, rov_s, rd_s} !== {1'b1, 1'b1, 8'd255}) begin errors++; $display("FAIL sat_read_ch0 got v%b o%b d%0d exp v1 o1 d255", rv_s, rov_s, rd_s); end
    tick();
    checks++; if ({rv_s, rov_s, rd_s} !== {1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL read_out_of_range got v%b o%b d%0d exp v1 o0 d0", rv_s, rov_s, rd_s); end
    pulsein = 16'h0001;
    repeat (5) tick();
    snapshot_seq();
    checks++; if (so_s[7:0] !== 8'd5) begin errors++; $display("FAIL sat_next_value got %0d exp 5", so_s[7:0]); end
    checks++; if (ovf_s[0] !== 1'b0) begin errors++; $display("FAIL sat_next_ovf got %b exp 0", ovf_s[0]); end
    checks++; if ({ovf_w[0], so_w[7:0]} !== {1'b0, 8'd5}) begin errors++; $display("FAIL wrap_next got o%b d%0d exp o0 d5", ovf_w[0], so_w[7:0]); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pulsein = 16'h0001;
    repeat (5) tick();
    pm_tick = 1'b1;
    tick();                       // edge 0
    tick();                       // edge 1
    pm_tick = 1'b0;
    tick();                       // edge 2
    checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL b2b_sv_e2 got %b exp 1", sv_m); end
    tick();                       // edge 3
    checks++; if (so_m[47:0] !== 48'd6) begin errors++; $display("FAIL b2b_first got %0d exp 6", so_m[47:0]); end
    checks++; if (sv_m !== 1'b1) begin errors++; $display("FAIL b2b_sv_e3 got %b exp 1", sv_m); end
    tick();                       // edge 4
    checks++; if (so_m[47:0] !== 48'd1) begin errors++; $display("FAIL b2b_second got %0d exp 1", so_m[47:0]); end
    checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL b2b_sv_e4 got %b exp 0", sv_m); end
  endtask

  task automatic test_hold();
    apply_reset();
    hold_output = 1'b1;
    pulsein = 16'h0001;
    repeat (10) tick();
    snapshot_seq();
    checks++; if (so_m[47:0] !== 48'd0) begin errors++; $display("FAIL hold_first got %0d exp 0", so_m[47:0]); end
    pulsein = 16'h0001;
    repeat (20) tick();
    snapshot_seq();
    checks++; if (so_m[47:0] !== 48'd0) begin errors++; $display("FAIL hold_second got %0d exp 0", so_m[47:0]); end
    hold_output = 1'b0;
    tick();
    checks++; if (so_m[47:0] !== 48'd20) begin errors++; $display("FAIL hold_release got %0d exp 20", so_m[47:0]); end
  endtask

  task automatic test_reset_mid();
    pulsein = 16'h0001;
    repeat (7) tick();
    pulsein = '0; pm_tick = 1'b1;
    tick();                       // edge 0
    pm_tick = 1'b0; reset = 1'b1;
    tick();                       // edge 1
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL rstmid_sv_%0d got %b exp 0", i, sv_m); end
      tick();
    end
    checks++; if (so_m !== '0) begin errors++; $display("FAIL rstmid_statsout got %0h exp 0", so_m); end
    reset = 1'b1; pm_tick = 1'b1;
    tick();
    reset = 1'b0; pm_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (sv_m !== 1'b0) begin errors++; $display("FAIL rsttick_sv_%0d got %b exp 0", i, sv_m); end
    end
  endtask

  initial begin
    test_reset();
    test_counts();
    test_read();
    test_sat_wrap();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
